flit_injector: RTL and testbench

FLIT_INJECTOR -- requirements
Module: flit_injector

---
 rtl/flit_injector.sv | 74 +++++++
 tb/tb_flit_injector.sv | 136 +++++++++++++
 2 files changed

// File: rtl/flit_injector.sv
// Injection queue between a local flit generator and a router input port.
// Queued flits age every cycle so the router's age-priority comparator can favour old traffic.
module flit_injector #(
    parameter int NODE_ID = 0,
    parameter int DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gen_valid,
    input  logic [3:0]  gen_dest,
    output logic        gen_ready,
    input  logic        inj_slot_free,
    output logic [12:0] control_out,
    output logic        inj_fire,
    output logic [3:0]  occupancy,
    output logic        age_sat
);

    localparam int          PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  SRC = 4'(NODE_ID);
    localparam logic [3:0]  CAP = 4'(DEPTH);

    logic [3:0]    dest_q [DEPTH];
    logic [3:0]    age_q  [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [3:0]    count;
    logic          push;
    logic          pop;
    logic          not_empty;

    function automatic logic [3:0] age_inc(input logic [3:0] a);
        return (a == 4'hF) ? a : a + 4'd1;
    endfunction

    assign not_empty   = (count != 4'd0);
    assign gen_ready   = (count < CAP);
    assign control_out = not_empty ? {1'b1, dest_q[rd_ptr], SRC, age_q[rd_ptr]} : 13'h0000;
    assign inj_fire    = control_out[12] && inj_slot_free;
    assign age_sat     = control_out[12] && (control_out[3:0] == 4'hF);
    assign occupancy   = count;
    assign push        = gen_valid && gen_ready;
    assign pop         = inj_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= 4'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    // Slots outside the occupied window also age, but any slot is cleared to age 0 when written,
    // so only resident entries are ever observed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push && (wr_ptr == PW'(i))) begin
                dest_q[i] <= gen_dest;
                age_q[i]  <= 4'h0;
            end else begin
                age_q[i]  <= age_inc(age_q[i]);
            end
        end
    end

endmodule

// File: tb/tb_flit_injector.sv
// Bench for flit_injector: directed scenarios plus random traffic against a queue-based reference.
module tb_flit_injector;

    localparam int NODE = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        gen_valid;
    logic [3:0]  gen_dest;
    logic        gen_ready;
    logic        inj_slot_free;
    logic [12:0] control_out;
    logic        inj_fire;
    logic [3:0]  occupancy;
    logic        age_sat;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [3:0] dest;
        logic [3:0] age;
    } ent_t;
    ent_t q[$];

    flit_injector #(.NODE_ID(NODE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .gen_valid(gen_valid), .gen_dest(gen_dest),
        .gen_ready(gen_ready), .inj_slot_free(inj_slot_free), .control_out(control_out),
        .inj_fire(inj_fire), .occupancy(occupancy), .age_sat(age_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Expected outputs straight from the queue contents.
    task automatic check_all(input string tag);
        logic [12:0] ectl;
        ectl = (q.size() > 0) ? {1'b1, q[0].dest, 4'(NODE), q[0].age} : 13'h0000;
        chk({tag, "_ctl"},   control_out, ectl);
        chk({tag, "_fire"},  13'(inj_fire), 13'(ectl[12] && inj_slot_free));
        chk({tag, "_occ"},   13'(occupancy), 13'(q.size()));
        chk({tag, "_rdy"},   13'(gen_ready), 13'(q.size() < DEPTH));
        chk({tag, "_sat"},   13'(age_sat), 13'(ectl[12] && ectl[3:0] == 4'hF));
    endtask

    // Drive at negedge, check, then advance one rising edge and update the reference.
    task automatic step(input string tag, input logic v, input logic [3:0] d, input logic s);
        bit fire;
        bit acc;
        gen_valid = v;
        gen_dest = d;
        inj_slot_free = s;
        #1;
        check_all(tag);
        fire = (q.size() > 0) && s;
        acc  = v && (q.size() < DEPTH);
        @(posedge clk);
        if (fire) void'(q.pop_front());
        foreach (q[i]) if (q[i].age != 4'hF) q[i].age = q[i].age + 4'd1;
        if (acc) q.push_back('{dest: d, age: 4'h0});
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        q.delete();
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        gen_valid = 1'b0;
        gen_dest = 4'h0;
        inj_slot_free = 1'b0;
        @(negedge clk);
        do_reset();

        // single flit aging then injection
        step("push5", 1'b1, 4'h5, 1'b0);
        chk("ex_age0", control_out, 13'h1520);
        step("wait1", 1'b0, 4'h0, 1'b0);
        step("wait2", 1'b0, 4'h0, 1'b0);
        step("wait3", 1'b0, 4'h0, 1'b0);
        chk("ex_age3", control_out, 13'h1523);
        step("fire", 1'b0, 4'h0, 1'b1);
        chk("ex_empty", control_out, 13'h0000);

        // fill, then full-queue push+pop refuses the push
        for (int k = 1; k <= 4; k++) step("fill", 1'b1, 4'(k), 1'b0);
        chk("ex_full_head", control_out, 13'h1123);
        chk("ex_full_rdy", 13'(gen_ready), 13'h0);
        step("full_pp", 1'b1, 4'hA, 1'b1);
        chk("ex_occ3", 13'(occupancy), 13'h3);
        for (int k = 0; k < 3; k++) step("drain", 1'b0, 4'h0, 1'b1);
        step("idle_slot", 1'b0, 4'h0, 1'b1);

        // saturation after 15 edges
        step("push_sat", 1'b1, 4'(NODE), 1'b0);
        for (int k = 0; k < 20; k++) step("hold", 1'b0, 4'h0, 1'b0);
        chk("ex_sat", control_out, 13'h12_2F);
        step("sat_pop", 1'b0, 4'h0, 1'b1);

        // steady push+pop across pointer wrap
        step("pp_a", 1'b1, 4'h7, 1'b0);
        step("pp_b", 1'b1, 4'h8, 1'b0);
        for (int k = 0; k < 6; k++) step("pp", 1'b1, 4'(9 + k), 1'b1);
        chk("ex_pp_occ", 13'(occupancy), 13'h2);

        // asynchronous reset between edges, then first push stores age 0
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b0;
        step("post_rst", 1'b1, 4'h3, 1'b0);
        chk("ex_post_rst", control_out, 13'h1320);

        for (int k = 0; k < 400; k++)
            step("rand", 1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 9) < 4));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
